// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared motion-estimation types, field widths and address helpers
// Purpose: field widths of the packed SAD result word, the tracker state
//          encoding, and row/column split of a candidate address.
// Contents: SAD_W, ADDR_W, IN_W; state_t {IDLE, SEARCH, DONE};
//           mv_addr_row(), mv_addr_col().
package me_pkg;

    localparam int SAD_W  = 12;
    localparam int ADDR_W = 8;
    localparam int IN_W   = 21;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Candidate address carries the row in the upper half, column in the lower.
    function automatic logic [ADDR_W/2-1:0] mv_addr_row(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:ADDR_W/2];
    endfunction

    function automatic logic [ADDR_W/2-1:0] mv_addr_col(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W/2-1:0];
    endfunction

endpackage

// File: rtl/sad_min_tracker_if.sv
// rtl/sad_min_tracker_if.sv - candidate stream in / search result out bundle
// Purpose: groups the SAD candidate input and the search result outputs.
// Signals: start, res_valid, res_in[IN_W]      (controller/SAD stage -> tracker)
//          busy, done, best_valid, best_sad[SAD_W], best_addr[ADDR_W],
//          cand_cnt[8]                          (tracker -> controller)
// Modports: master = controller side, slave = tracker side.
interface sad_min_tracker_if;
    import me_pkg::*;

    logic              start;
    logic              res_valid;
    logic [IN_W-1:0]   res_in;
    logic              busy;
    logic              done;
    logic              best_valid;
    logic [SAD_W-1:0]  best_sad;
    logic [ADDR_W-1:0] best_addr;
    logic [7:0]        cand_cnt;

    modport master (
        output start, res_valid, res_in,
        input  busy, done, best_valid, best_sad, best_addr, cand_cnt
    );

    modport slave (
        input  start, res_valid, res_in,
        output busy, done, best_valid, best_sad, best_addr, cand_cnt
    );

endinterface

// File: rtl/sad_min_tracker.sv
// rtl/sad_min_tracker.sv - minimum-SAD tracker over one motion search window
// Purpose: accepts NUM_CAND valid {sad, addr} candidates after a start pulse,
//          keeps the first strictly-smallest SAD and its address, then pulses
//          done and holds the result until the next start.
// Ports:   clk   - system clock, rising edge
//          rst_n - asynchronous active-low reset
//          bus   - sad_min_tracker_if.slave (start/res_valid/res_in in;
//                  busy/done/best_valid/best_sad/best_addr/cand_cnt out)
// Build option: SAD_EARLY_EXIT_EN - a zero-SAD candidate ends the search at once.
module sad_min_tracker
    import me_pkg::*;
#(
    parameter int NUM_CAND = 49
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sad_min_tracker_if.slave     bus
);

    localparam logic [7:0] CNT_LAST = 8'(NUM_CAND - 1);
    localparam logic [7:0] CNT_MAX  = 8'(NUM_CAND);

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_best_valid;
    logic [SAD_W-1:0]  r_best_sad;
    logic [ADDR_W-1:0] r_best_addr;
    logic [7:0]        r_cnt;

    logic [SAD_W-1:0]  w_sad;
    logic [ADDR_W-1:0] w_addr;
    logic              w_better;
    logic              w_finish;
    logic              w_unused_pad;

    assign w_sad        = bus.res_in[ADDR_W+SAD_W-1:ADDR_W];
    assign w_addr       = bus.res_in[ADDR_W-1:0];
    assign w_unused_pad = ^bus.res_in[IN_W-1:ADDR_W+SAD_W];

    // The first candidate always loads, so a SAD equal to the all-ones seed still wins.
    assign w_better = (r_cnt == 8'd0) || (w_sad < r_best_sad);

`ifdef SAD_EARLY_EXIT_EN
    assign w_finish = (r_cnt == CNT_LAST) || (w_sad == '0);
`else
    assign w_finish = (r_cnt == CNT_LAST);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_best_valid <= 1'b0;
            r_best_sad   <= '1;
            r_best_addr  <= '0;
            r_cnt        <= 8'd0;
        end else begin
            r_done <= 1'b0;
            // start has priority in every state: it also discards a same-cycle
            // candidate and suppresses the done pulse of a search it cuts short.
            if (bus.start) begin
                r_state      <= SEARCH;
                r_busy       <= 1'b1;
                r_best_valid <= 1'b0;
                r_best_sad   <= '1;
                r_best_addr  <= '0;
                r_cnt        <= 8'd0;
            end else if (r_state == SEARCH && bus.res_valid) begin
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + 8'd1;
                end
                if (w_better) begin
                    r_best_sad  <= w_sad;
                    r_best_addr <= w_addr;
                end
                if (w_finish) begin
                    r_state      <= DONE;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b1;
                    r_best_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.best_valid = r_best_valid;
    assign bus.best_sad   = r_best_sad;
    assign bus.best_addr  = r_best_addr;
    assign bus.cand_cnt   = r_cnt;

endmodule

// File: tb/tb_sad_min_tracker.sv
// tb/tb_sad_min_tracker.sv - self-checking bench for sad_min_tracker
module tb_sad_min_tracker;
    import me_pkg::*;

    localparam int NC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    int   q_sad[$];
    int   q_addr[$];

    sad_min_tracker_if bus ();

    sad_min_tracker #(.NUM_CAND(NC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IN_W-1:0] pack(input int sad, input int addr);
        logic       pad;
        logic [IN_W-1:0] w;
        pad = 1'($urandom);
        w = {pad, 12'(sad), 8'(addr)};
        return w;
    endfunction

    task automatic do_cycle(input logic s, input logic v, input logic [IN_W-1:0] d);
        bus.start     = s;
        bus.res_valid = v;
        bus.res_in    = d;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.res_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},  32'(bus.busy), 0);
        check({tag, "_done"},  32'(bus.done), 0);
        check({tag, "_bv"},    32'(bus.best_valid), 0);
        check({tag, "_sad"},   32'(bus.best_sad), 32'hFFF);
        check({tag, "_addr"},  32'(bus.best_addr), 0);
        check({tag, "_cnt"},   32'(bus.cand_cnt), 0);
    endtask

    // Reference: the search ends at candidate NC-1, or at the first zero SAD
    // when early exit is built in; the result is the smallest SAD among the
    // accepted candidates and the address of its first occurrence.
    task automatic run_search(input string tag, input bit gaps);
        int n, term, exp_min, exp_idx;
        n = q_sad.size();
        term = (n >= NC) ? NC - 1 : -1;
`ifdef SAD_EARLY_EXIT_EN
        for (int i = 0; i < n && i < NC; i++) begin
            if (q_sad[i] == 0) begin
                term = i;
                break;
            end
        end
`endif
        do_cycle(1'b1, 1'b0, '0);
        check({tag, "_busy_start"}, 32'(bus.busy), 1);
        check({tag, "_cnt_start"}, 32'(bus.cand_cnt), 0);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1 || i % 2 == 1)) begin
                do_cycle(1'b0, 1'b0, IN_W'($urandom));
                check({tag, "_gap_done"}, 32'(bus.done), 0);
            end
            do_cycle(1'b0, 1'b1, pack(q_sad[i], q_addr[i]));
            check({tag, "_done_at"}, 32'(bus.done), (i == term) ? 1 : 0);
        end
        if (term >= 0) begin
            exp_min = 32'hFFF;
            for (int i = 0; i <= term; i++) exp_min = (q_sad[i] < exp_min) ? q_sad[i] : exp_min;
            exp_idx = -1;
            for (int i = 0; i <= term; i++) if (exp_idx < 0 && q_sad[i] == exp_min) exp_idx = i;
            do_cycle(1'b0, 1'b0, '0);
            check({tag, "_done_pulse_end"}, 32'(bus.done), 0);
            check({tag, "_busy_end"}, 32'(bus.busy), 0);
            check({tag, "_bv"}, 32'(bus.best_valid), 1);
            check({tag, "_sad"}, 32'(bus.best_sad), 32'(exp_min));
            check({tag, "_addr"}, 32'(bus.best_addr), 32'(q_addr[exp_idx]));
            check({tag, "_cnt"}, 32'(bus.cand_cnt), 32'(term + 1));
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_in = '0;

        // Reset and idle
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        do_cycle(1'b0, 1'b1, pack(3, 8'h12));
        do_cycle(1'b0, 1'b1, pack(0, 8'h34));
        check_reset_vals("idle_valid");

        // Basic search, tie keeps the first
        q_sad = '{100, 40, 75, 40};
        q_addr = '{'h11, 'h22, 'h33, 'h44};
        run_search("basic", 1'b0);
        do_cycle(1'b0, 1'b0, '0);
        check("hold_sad", 32'(bus.best_sad), 40);
        check("hold_bv", 32'(bus.best_valid), 1);
        check("hold_done", 32'(bus.done), 0);

        // Gapped valid
        run_search("gapped", 1'b1);

        // All-ones SADs: first candidate must still load
        q_sad = '{'hFFF, 'hFFF, 'hFFF, 'hFFF};
        q_addr = '{'h51, 'h52, 'h53, 'h54};
        run_search("allones", 1'b0);

        // Abort: restart mid-search, same-cycle candidate discarded
        do_cycle(1'b1, 1'b0, '0);
        do_cycle(1'b0, 1'b1, pack(5, 'h13));
        do_cycle(1'b0, 1'b1, pack(20, 'h14));
        do_cycle(1'b1, 1'b1, pack(1, 'h15));
        check("abort_done", 32'(bus.done), 0);
        check("abort_busy", 32'(bus.busy), 1);
        check("abort_cnt", 32'(bus.cand_cnt), 0);
        check("abort_bv", 32'(bus.best_valid), 0);
        check("abort_sad", 32'(bus.best_sad), 32'hFFF);
        q_sad = '{12, 9, 15, 9};
        q_addr = '{'h30, 'h31, 'h32, 'h33};
        run_search("after_abort", 1'b0);

        // Start coinciding with the final candidate
        do_cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < NC - 1; i++) do_cycle(1'b0, 1'b1, pack(50 + i, i));
        do_cycle(1'b1, 1'b1, pack(60, 'h77));
        check("startlast_done", 32'(bus.done), 0);
        check("startlast_busy", 32'(bus.busy), 1);
        check("startlast_cnt", 32'(bus.cand_cnt), 0);

        // Asynchronous reset mid-search
        do_cycle(1'b1, 1'b0, '0);
        do_cycle(1'b0, 1'b1, pack(7, 'h21));
        do_cycle(1'b0, 1'b1, pack(8, 'h22));
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        q_sad = '{300, 200, 250, 199};
        q_addr = '{'h01, 'h02, 'h03, 'h04};
        run_search("post_rst", 1'b0);

        // Zero SAD in the middle of the window
        do_cycle(1'b1, 1'b0, '0);
        do_cycle(1'b0, 1'b1, pack(30, 'h29));
        do_cycle(1'b0, 1'b1, pack(0, 'h2A));
`ifdef SAD_EARLY_EXIT_EN
        check("ee_done", 32'(bus.done), 1);
        do_cycle(1'b0, 1'b1, pack(7, 'h2B));
        check("ee_busy", 32'(bus.busy), 0);
        check("ee_sad", 32'(bus.best_sad), 0);
        check("ee_addr", 32'(bus.best_addr), 'h2A);
        check("ee_cnt", 32'(bus.cand_cnt), 2);
`else
        check("ee_done", 32'(bus.done), 0);
        do_cycle(1'b0, 1'b1, pack(7, 'h2B));
        check("ee_busy", 32'(bus.busy), 1);
        check("ee_cnt", 32'(bus.cand_cnt), 3);
        do_cycle(1'b0, 1'b1, pack(0, 'h2C));
        check("ee_done4", 32'(bus.done), 1);
        check("ee_sad", 32'(bus.best_sad), 0);
        check("ee_addr", 32'(bus.best_addr), 'h2A);
        check("ee_cnt4", 32'(bus.cand_cnt), 4);
`endif

        // Randomized searches
        for (int k = 0; k < 30; k++) begin
            q_sad.delete();
            q_addr.delete();
            for (int i = 0; i < NC; i++) begin
                q_sad.push_back((k % 3 == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 12)));
                q_addr.push_back(int'($urandom_range(0, 255)));
            end
            run_search("rand", 1'(k % 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
